// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - shared types for the MIPS multiply/divide unit
// Op encodings, FSM states and op-class helpers.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    OP_MULT   = 3'd0,
    OP_MULTU  = 3'd1,
    OP_DIV    = 3'd2,
    OP_DIVU   = 3'd3,
    OP_MTHI   = 3'd4,
    OP_MTLO   = 3'd5,
    OP_RSVD6  = 3'd6,
    OP_RSVD7  = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } muldiv_state_t;

  localparam muldiv_op_t OP_RSVD_FIRST = OP_RSVD6;
  localparam muldiv_op_t OP_RSVD_LAST  = OP_RSVD7;

  function automatic logic op_is_iterative(input muldiv_op_t op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction

  function automatic logic op_is_signed(input muldiv_op_t op);
    return op inside {OP_MULT, OP_DIV};
  endfunction

  function automatic logic op_is_div(input muldiv_op_t op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

endpackage

// File: rtl/mips_cpu_muldiv_if.sv
// rtl/mips_cpu_muldiv_if.sv - request/result bundle between pipeline and mul/div unit
// master = pipeline side, slave = mul/div unit.
interface mips_cpu_muldiv_if
  import mips_cpu_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] rs_content;
  logic [WIDTH-1:0] rt_content;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_content, rt_content,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_content, rt_content,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mips_cpu_muldiv_datapath.sv
// rtl/mips_cpu_muldiv_datapath.sv - radix-2 shift-add / restoring-divide engine
// Works on magnitudes; signs are reapplied combinationally into hi_next/lo_next.
module mips_cpu_muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             fixup,
  input  logic             is_signed,
  input  logic             is_div,
  input  logic [WIDTH-1:0] rs_content,
  input  logic [WIDTH-1:0] rt_content,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next,
  output logic             div_zero
);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   raw_rs;
  logic               div_mode;
  logic               neg_res;
  logic               neg_rem;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    a_neg = is_signed & rs_content[WIDTH-1];
    b_neg = is_signed & rt_content[WIDTH-1];
    a_mag = a_neg ? -rs_content : rs_content;
    b_mag = b_neg ? -rt_content : rt_content;
  end

  // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, operand};
    div_diff  = div_shift[WIDTH-1:0] - operand;
    if (div_mode) begin
      acc_step = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_signed = neg_res ? -acc : acc;
    quot        = acc[WIDTH-1:0];
    rem         = acc[2*WIDTH-1:WIDTH];
    hi_next     = prod_signed[2*WIDTH-1:WIDTH];
    lo_next     = prod_signed[WIDTH-1:0];
    if (div_mode) begin
      if (div_zero) begin
        hi_next = raw_rs;
        lo_next = '1;
      end else begin
        hi_next = neg_rem ? -rem : rem;
        lo_next = neg_res ? -quot : quot;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      operand  <= '0;
      raw_rs   <= '0;
      div_mode <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else if (load) begin
      acc      <= {{WIDTH{1'b0}}, a_mag};
      operand  <= b_mag;
      raw_rs   <= rs_content;
      div_mode <= is_div;
      neg_res  <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      div_zero <= is_div && (rt_content == '0);
    end else if (step) begin
      acc <= acc_step;
    end else if (fixup) begin
      acc <= '0;
    end
  end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// rtl/mips_cpu_muldiv.sv - multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO
// FSM, iteration counter, architectural HI/LO and the sticky divide-by-zero flag.
module mips_cpu_muldiv
  import mips_cpu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  mips_cpu_muldiv_if.slave bus
);

  muldiv_state_t    state;
  muldiv_state_t    state_next;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             load;
  logic             step;
  logic             fixup;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;
  logic             done_q;
  logic             dz_q;
  logic             dp_div_zero;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    fixup      = 1'b0;
    case (state)
      IDLE: begin
        accept = bus.start;
        load   = bus.start && op_is_iterative(bus.op);
        if (load) state_next = CALC;
      end
      CALC: begin
        step = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) state_next = FIXUP;
      end
      FIXUP: begin
        fixup      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        cnt <= '0;
      end else if (step) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // HI/LO only move on MTHI/MTLO in IDLE or on the single FIXUP edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= fixup;
      if (fixup) begin
        hi_q <= hi_next;
        lo_q <= lo_next;
        if (dp_div_zero) dz_q <= 1'b1;
      end else if (accept) begin
        if (bus.op == OP_MTHI) hi_q <= bus.rs_content;
        if (bus.op == OP_MTLO) lo_q <= bus.rs_content;
        if (load) dz_q <= 1'b0;
      end
    end
  end

  mips_cpu_muldiv_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .step       (step),
    .fixup      (fixup),
    .is_signed  (op_is_signed(bus.op)),
    .is_div     (op_is_div(bus.op)),
    .rs_content (bus.rs_content),
    .rt_content (bus.rt_content),
    .hi_next    (hi_next),
    .lo_next    (lo_next),
    .div_zero   (dp_div_zero)
  );

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule
